// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// cpu_bus_pkg : shared types and default regions for the CPU/host bus routers
// Revision    : 1.0
// ============================================================================
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACK    = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Block RAM occupies the bottom 512 KB; SDRAM catches everything else.
    localparam logic [31:0] c_BRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] c_BRAM_MASK  = 32'hFFF8_0000;
    localparam logic [31:0] c_SDRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] c_SDRAM_MASK = 32'h0000_0000;

    localparam int c_MAX_TARGETS = 8;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_region_decode.sv
`default_nettype none
// ============================================================================
// bus_region_decode : combinational base/mask matcher, lowest index wins
// Revision          : 1.0
// ============================================================================
module bus_region_decode #(
    parameter int NUM_TARGETS = 2,
    parameter int ADDR_W      = 32,
    parameter int IDX_W       = 1
) (
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [NUM_TARGETS*ADDR_W-1:0] i_region_base,
    input  logic [NUM_TARGETS*ADDR_W-1:0] i_region_mask,
    output logic                          o_hit,
    output logic [IDX_W-1:0]              o_idx
);

    logic [NUM_TARGETS-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_match
            assign w_match[gi] = ((i_addr & i_region_mask[gi*ADDR_W +: ADDR_W])
                                  == i_region_base[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_router.sv
`default_nettype none
// ============================================================================
// cpu_bus_router : 68k-style CPU bus cycle decode and target req/ack handshake
// Revision       : 1.0
// ============================================================================
module cpu_bus_router
    import cpu_bus_pkg::*;
#(
    parameter int                            NUM_TARGETS    = 2,
    parameter int                            ADDR_W         = 32,
    parameter int                            DATA_W         = 32,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_BASE    = {c_SDRAM_BASE, c_BRAM_BASE},
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_MASK    = {c_SDRAM_MASK, c_BRAM_MASK},
    parameter int                            TIMEOUT_CYCLES = 255
) (
    input  logic                                              CLK_114,
    input  logic                                              RESET_N,
    input  logic [ADDR_W-1:0]                                 cpu_addr,
    input  logic [DATA_W-1:0]                                 cpu_wdata,
    input  logic                                              cpu_as_n,
    input  logic                                              cpu_rw_n,
    input  logic [DATA_W/8-1:0]                               cpu_be_n,
    output logic [DATA_W-1:0]                                 cpu_rdata,
    output logic                                              cpu_dtack_n,
    output logic                                              cpu_berr_n,
    output logic [NUM_TARGETS-1:0]                            tgt_sel_n,
    output logic [NUM_TARGETS-1:0]                            tgt_rw_n,
    output logic [ADDR_W-1:0]                                 tgt_addr,
    output logic [DATA_W-1:0]                                 tgt_wdata,
    output logic [DATA_W/8-1:0]                               tgt_be_n,
    input  logic [NUM_TARGETS*DATA_W-1:0]                     tgt_rdata,
    input  logic [NUM_TARGETS-1:0]                            tgt_dtack_n,
    output logic [(NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1)-1:0] active_tgt
);

    localparam int                 c_IDX_W      = clog2_min1(NUM_TARGETS);
    localparam int                 c_CNT_W      = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam int                 c_BE_W       = DATA_W / 8;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT_CYCLES);
    localparam bit                 c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t                   r_state,   w_state_nxt;
    logic [ADDR_W-1:0]        r_addr,    w_addr_nxt;
    logic [DATA_W-1:0]        r_wdata,   w_wdata_nxt;
    logic [c_BE_W-1:0]        r_be_n,    w_be_n_nxt;
    logic                     r_rw_n,    w_rw_n_nxt;
    logic [NUM_TARGETS-1:0]   r_sel_n,   w_sel_n_nxt;
    logic [NUM_TARGETS-1:0]   r_tgt_rw_n, w_tgt_rw_n_nxt;
    logic [c_IDX_W-1:0]       r_active,  w_active_nxt;
    logic [c_CNT_W-1:0]       r_cnt,     w_cnt_nxt;
    logic [DATA_W-1:0]        r_rdata,   w_rdata_nxt;
    logic                     r_dtack_n, w_dtack_n_nxt;
    logic                     r_berr_n,  w_berr_n_nxt;

    // Target acknowledge and read data are registered once before the FSM sees them.
    logic [NUM_TARGETS-1:0]   r_tgt_dtack_n;
    logic [DATA_W-1:0]        r_rdata_smp;

    logic                     w_dec_hit;
    logic [c_IDX_W-1:0]       w_dec_idx;
    logic [c_CNT_W-1:0]       w_cnt_inc;

    bus_region_decode #(
        .NUM_TARGETS (NUM_TARGETS),
        .ADDR_W      (ADDR_W),
        .IDX_W       (c_IDX_W)
    ) u_decode (
        .i_addr        (r_addr),
        .i_region_base (REGION_BASE),
        .i_region_mask (REGION_MASK),
        .o_hit         (w_dec_hit),
        .o_idx         (w_dec_idx)
    );

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);

    always_ff @(posedge CLK_114 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be_n        <= '1;
            r_rw_n        <= 1'b1;
            r_sel_n       <= '1;
            r_tgt_rw_n    <= '1;
            r_active      <= '0;
            r_cnt         <= '0;
            r_rdata       <= '0;
            r_dtack_n     <= 1'b1;
            r_berr_n      <= 1'b1;
            r_tgt_dtack_n <= '1;
            r_rdata_smp   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_be_n        <= w_be_n_nxt;
            r_rw_n        <= w_rw_n_nxt;
            r_sel_n       <= w_sel_n_nxt;
            r_tgt_rw_n    <= w_tgt_rw_n_nxt;
            r_active      <= w_active_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rdata       <= w_rdata_nxt;
            r_dtack_n     <= w_dtack_n_nxt;
            r_berr_n      <= w_berr_n_nxt;
            r_tgt_dtack_n <= tgt_dtack_n;
            r_rdata_smp   <= tgt_rdata[r_active*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_be_n_nxt     = r_be_n;
        w_rw_n_nxt     = r_rw_n;
        w_sel_n_nxt    = r_sel_n;
        w_tgt_rw_n_nxt = r_tgt_rw_n;
        w_active_nxt   = r_active;
        w_cnt_nxt      = r_cnt;
        w_rdata_nxt    = r_rdata;
        w_dtack_n_nxt  = r_dtack_n;
        w_berr_n_nxt   = r_berr_n;

        case (r_state)
            ST_IDLE: begin
                if (!cpu_as_n) begin
                    w_addr_nxt  = cpu_addr;
                    w_wdata_nxt = cpu_wdata;
                    w_be_n_nxt  = cpu_be_n;
                    w_rw_n_nxt  = cpu_rw_n;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cpu_as_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dec_hit) begin
                    w_sel_n_nxt               = '1;
                    w_sel_n_nxt[w_dec_idx]    = 1'b0;
                    w_tgt_rw_n_nxt            = '1;
                    w_tgt_rw_n_nxt[w_dec_idx] = r_rw_n;
                    w_active_nxt              = w_dec_idx;
                    w_cnt_nxt                 = '0;
                    w_state_nxt               = ST_WAIT;
                end else begin
                    w_berr_n_nxt = 1'b0;
                    w_state_nxt  = ST_ERR;
                end
            end
            ST_WAIT: begin
                // Abort beats acknowledge, acknowledge beats timeout.
                if (cpu_as_n) begin
                    w_sel_n_nxt    = '1;
                    w_tgt_rw_n_nxt = '1;
                    w_state_nxt    = ST_IDLE;
                end else if (!r_tgt_dtack_n[r_active]) begin
                    if (r_rw_n) begin
                        w_rdata_nxt = r_rdata_smp;
                    end
                    w_sel_n_nxt    = '1;
                    w_tgt_rw_n_nxt = '1;
                    w_dtack_n_nxt  = 1'b0;
                    w_state_nxt    = ST_ACK;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (c_TIMEOUT_EN && (w_cnt_inc == c_TIMEOUT)) begin
                        w_sel_n_nxt    = '1;
                        w_tgt_rw_n_nxt = '1;
                        w_berr_n_nxt   = 1'b0;
                        w_state_nxt    = ST_ERR;
                    end
                end
            end
            ST_ACK: begin
                if (cpu_as_n) begin
                    w_dtack_n_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (cpu_as_n) begin
                    w_berr_n_nxt = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_sel_n_nxt    = '1;
                w_tgt_rw_n_nxt = '1;
                w_dtack_n_nxt  = 1'b1;
                w_berr_n_nxt   = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    assign cpu_rdata   = r_rdata;
    assign cpu_dtack_n = r_dtack_n;
    assign cpu_berr_n  = r_berr_n;
    assign tgt_sel_n   = r_sel_n;
    assign tgt_rw_n    = r_tgt_rw_n;
    assign tgt_addr    = r_addr;
    assign tgt_wdata   = r_wdata;
    assign tgt_be_n    = r_be_n;
    assign active_tgt  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_router.sv
`default_nettype none
// ============================================================================
// tb_cpu_bus_router : directed bench for cpu_bus_router
// Revision          : 1.0
// ============================================================================
module tb_cpu_bus_router;

    logic        CLK_114;
    logic        RESET_N;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_as_n;
    logic        cpu_rw_n;
    logic [3:0]  cpu_be_n;
    logic [63:0] tgt_rdata;
    logic [1:0]  tgt_dtack_n;

    logic [31:0] cpu_rdata;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;
    logic [1:0]  tgt_sel_n;
    logic [1:0]  tgt_rw_n;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_wdata;
    logic [3:0]  tgt_be_n;
    logic [0:0]  active_tgt;

    // Second instance: restricted map so that some addresses are unmapped.
    logic [63:0] tgt_rdata_b;
    logic [1:0]  tgt_dtack_n_b;
    logic [31:0] cpu_rdata_b;
    logic        cpu_dtack_n_b;
    logic        cpu_berr_n_b;
    logic [1:0]  tgt_sel_n_b;
    logic [1:0]  tgt_rw_n_b;
    logic [31:0] tgt_addr_b;
    logic [31:0] tgt_wdata_b;
    logic [3:0]  tgt_be_n_b;
    logic [0:0]  active_tgt_b;

    int vecs = 0;
    int errs = 0;

    cpu_bus_router #(
        .NUM_TARGETS    (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .REGION_BASE    ({32'h0000_0000, 32'h0000_0000}),
        .REGION_MASK    ({32'h0000_0000, 32'hFFF8_0000}),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK_114     (CLK_114),
        .RESET_N     (RESET_N),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_as_n    (cpu_as_n),
        .cpu_rw_n    (cpu_rw_n),
        .cpu_be_n    (cpu_be_n),
        .cpu_rdata   (cpu_rdata),
        .cpu_dtack_n (cpu_dtack_n),
        .cpu_berr_n  (cpu_berr_n),
        .tgt_sel_n   (tgt_sel_n),
        .tgt_rw_n    (tgt_rw_n),
        .tgt_addr    (tgt_addr),
        .tgt_wdata   (tgt_wdata),
        .tgt_be_n    (tgt_be_n),
        .tgt_rdata   (tgt_rdata),
        .tgt_dtack_n (tgt_dtack_n),
        .active_tgt  (active_tgt)
    );

    cpu_bus_router #(
        .NUM_TARGETS    (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .REGION_BASE    ({32'h0100_0000, 32'h0000_0000}),
        .REGION_MASK    ({32'hFF00_0000, 32'hFFF8_0000}),
        .TIMEOUT_CYCLES (4)
    ) dut_b (
        .CLK_114     (CLK_114),
        .RESET_N     (RESET_N),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_as_n    (cpu_as_n),
        .cpu_rw_n    (cpu_rw_n),
        .cpu_be_n    (cpu_be_n),
        .cpu_rdata   (cpu_rdata_b),
        .cpu_dtack_n (cpu_dtack_n_b),
        .cpu_berr_n  (cpu_berr_n_b),
        .tgt_sel_n   (tgt_sel_n_b),
        .tgt_rw_n    (tgt_rw_n_b),
        .tgt_addr    (tgt_addr_b),
        .tgt_wdata   (tgt_wdata_b),
        .tgt_be_n    (tgt_be_n_b),
        .tgt_rdata   (tgt_rdata_b),
        .tgt_dtack_n (tgt_dtack_n_b),
        .active_tgt  (active_tgt_b)
    );

    initial CLK_114 = 1'b0;
    always #5 CLK_114 = ~CLK_114;

    task automatic step();
        @(posedge CLK_114);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET_N       = 1'b0;
        cpu_addr      = 32'h0;
        cpu_wdata     = 32'h0;
        cpu_as_n      = 1'b1;
        cpu_rw_n      = 1'b1;
        cpu_be_n      = 4'hF;
        tgt_rdata     = 64'h0;
        tgt_dtack_n   = 2'b11;
        tgt_rdata_b   = 64'h0;
        tgt_dtack_n_b = 2'b11;

        // Reset values
        step();
        step();
        check("rst_dtack",  {63'h0, cpu_dtack_n}, 64'h1);
        check("rst_berr",   {63'h0, cpu_berr_n},  64'h1);
        check("rst_sel",    {62'h0, tgt_sel_n},   64'h3);
        check("rst_rw",     {62'h0, tgt_rw_n},    64'h3);
        check("rst_rdata",  {32'h0, cpu_rdata},   64'h0);
        check("rst_addr",   {32'h0, tgt_addr},    64'h0);
        check("rst_be",     {60'h0, tgt_be_n},    64'hF);
        check("rst_active", {63'h0, active_tgt},  64'h0);
        RESET_N = 1'b1;
        step();

        // Block RAM read, target 0 answers two cycles after select
        cpu_addr  = 32'h0000_1000;
        cpu_rw_n  = 1'b1;
        cpu_be_n  = 4'h0;
        cpu_as_n  = 1'b0;
        tgt_rdata = {32'hCAFE_F00D, 32'h1234_5678};
        step();
        check("rd_addr_latch", {32'h0, tgt_addr},  64'h0000_1000);
        check("rd_sel_edge0",  {62'h0, tgt_sel_n}, 64'h3);
        step();
        check("rd_sel",    {62'h0, tgt_sel_n},  64'h2);
        check("rd_rw",     {62'h0, tgt_rw_n},   64'h3);
        check("rd_active", {63'h0, active_tgt}, 64'h0);
        tgt_dtack_n = 2'b01;                    // unselected target acks: ignored
        step();
        check("rd_no_early_dtack", {63'h0, cpu_dtack_n}, 64'h1);
        tgt_dtack_n = 2'b10;
        step();
        check("rd_dtack_wait", {63'h0, cpu_dtack_n}, 64'h1);
        check("rd_sel_held",   {62'h0, tgt_sel_n},   64'h2);
        step();
        check("rd_dtack",     {63'h0, cpu_dtack_n}, 64'h0);
        check("rd_rdata",     {32'h0, cpu_rdata},   64'h1234_5678);
        check("rd_sel_drop",  {62'h0, tgt_sel_n},   64'h3);
        tgt_dtack_n = 2'b11;
        step();
        check("rd_dtack_hold", {63'h0, cpu_dtack_n}, 64'h0);
        cpu_as_n = 1'b1;
        step();
        check("rd_dtack_rel",  {63'h0, cpu_dtack_n}, 64'h1);

        // SDRAM write, zero-wait target 1
        cpu_addr  = 32'h0008_0000;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_be_n  = 4'h0;
        cpu_rw_n  = 1'b0;
        cpu_as_n  = 1'b0;
        tgt_rdata = {32'hCAFE_F00D, 32'h1111_2222};
        step();
        check("wr_wdata", {32'h0, tgt_wdata}, 64'hDEAD_BEEF);
        check("wr_be",    {60'h0, tgt_be_n},  64'h0);
        step();
        check("wr_sel",    {62'h0, tgt_sel_n},  64'h1);
        check("wr_rw",     {62'h0, tgt_rw_n},   64'h1);
        check("wr_active", {63'h0, active_tgt}, 64'h1);
        tgt_dtack_n = 2'b01;
        step();
        check("wr_dtack_wait", {63'h0, cpu_dtack_n}, 64'h1);
        step();
        check("wr_dtack",     {63'h0, cpu_dtack_n}, 64'h0);
        check("wr_rdata_kept", {32'h0, cpu_rdata},  64'h1234_5678);
        check("wr_rw_rel",    {62'h0, tgt_rw_n},    64'h3);
        tgt_dtack_n = 2'b11;
        cpu_as_n    = 1'b1;
        cpu_rw_n    = 1'b1;
        step();
        check("wr_dtack_rel", {63'h0, cpu_dtack_n}, 64'h1);

        // Timeout after four WAIT cycles
        cpu_addr = 32'h0000_2000;
        cpu_as_n = 1'b0;
        step();
        step();
        step();
        step();
        step();
        check("to_berr_wait", {63'h0, cpu_berr_n}, 64'h1);
        check("to_sel_wait",  {62'h0, tgt_sel_n},  64'h2);
        step();
        check("to_berr",   {63'h0, cpu_berr_n},  64'h0);
        check("to_sel",    {62'h0, tgt_sel_n},   64'h3);
        check("to_dtack",  {63'h0, cpu_dtack_n}, 64'h1);
        cpu_as_n = 1'b1;
        step();
        check("to_berr_rel", {63'h0, cpu_berr_n}, 64'h1);

        // Dtack lands on the timeout cycle: must complete normally
        cpu_addr  = 32'h0000_3000;
        cpu_as_n  = 1'b0;
        tgt_rdata = {32'hCAFE_F00D, 32'hA5A5_5A5A};
        step();
        step();
        step();
        step();
        tgt_dtack_n = 2'b10;
        step();
        check("col_pre_dtack", {63'h0, cpu_dtack_n}, 64'h1);
        step();
        check("col_dtack", {63'h0, cpu_dtack_n}, 64'h0);
        check("col_berr",  {63'h0, cpu_berr_n},  64'h1);
        check("col_rdata", {32'h0, cpu_rdata},   64'hA5A5_5A5A);
        tgt_dtack_n = 2'b11;
        cpu_as_n    = 1'b1;
        step();

        // Abort in WAIT, then a normal cycle
        cpu_addr = 32'h0000_4000;
        cpu_as_n = 1'b0;
        step();
        step();
        check("ab_sel_wait", {62'h0, tgt_sel_n}, 64'h2);
        cpu_as_n = 1'b1;
        step();
        check("ab_sel_rel", {62'h0, tgt_sel_n}, 64'h3);
        step();
        step();
        step();
        step();
        check("ab_no_dtack", {63'h0, cpu_dtack_n}, 64'h1);
        check("ab_no_berr",  {63'h0, cpu_berr_n},  64'h1);
        cpu_addr  = 32'h0010_0000;
        cpu_wdata = 32'h0BAD_F00D;
        cpu_rw_n  = 1'b0;
        cpu_as_n  = 1'b0;
        step();
        step();
        check("ab_next_sel",    {62'h0, tgt_sel_n},  64'h1);
        check("ab_next_active", {63'h0, active_tgt}, 64'h1);
        tgt_dtack_n = 2'b01;
        step();
        step();
        check("ab_next_dtack", {63'h0, cpu_dtack_n}, 64'h0);
        tgt_dtack_n = 2'b11;
        cpu_as_n    = 1'b1;
        cpu_rw_n    = 1'b1;
        step();

        // Unmapped address on the restricted instance
        cpu_addr = 32'h0200_0000;
        cpu_as_n = 1'b0;
        step();
        check("um_sel_edge0", {62'h0, tgt_sel_n_b}, 64'h3);
        step();
        check("um_berr",    {63'h0, cpu_berr_n_b}, 64'h0);
        check("um_sel",     {62'h0, tgt_sel_n_b},  64'h3);
        check("um_a_sel",   {62'h0, tgt_sel_n},    64'h1);
        step();
        check("um_berr_hold", {63'h0, cpu_berr_n_b}, 64'h0);
        check("um_sel_hold",  {62'h0, tgt_sel_n_b},  64'h3);
        cpu_as_n = 1'b1;
        step();
        check("um_berr_rel", {63'h0, cpu_berr_n_b}, 64'h1);

        // Reset asserted mid-WAIT on a target-1 write
        cpu_addr  = 32'h0010_0000;
        cpu_wdata = 32'h5555_AAAA;
        cpu_be_n  = 4'h3;
        cpu_rw_n  = 1'b0;
        cpu_as_n  = 1'b0;
        step();
        step();
        step();
        check("rs_sel_before", {62'h0, tgt_sel_n}, 64'h1);
        RESET_N = 1'b0;
        #1;
        check("rs_sel",    {62'h0, tgt_sel_n},   64'h3);
        check("rs_rw",     {62'h0, tgt_rw_n},    64'h3);
        check("rs_active", {63'h0, active_tgt},  64'h0);
        check("rs_addr",   {32'h0, tgt_addr},    64'h0);
        check("rs_wdata",  {32'h0, tgt_wdata},   64'h0);
        check("rs_be",     {60'h0, tgt_be_n},    64'hF);
        check("rs_rdata",  {32'h0, cpu_rdata},   64'h0);
        check("rs_dtack",  {63'h0, cpu_dtack_n}, 64'h1);
        check("rs_berr",   {63'h0, cpu_berr_n},  64'h1);
        tgt_dtack_n = 2'b01;
        cpu_as_n    = 1'b1;
        cpu_rw_n    = 1'b1;
        step();
        step();
        RESET_N = 1'b1;
        step();
        step();
        step();
        check("rs_no_dtack", {63'h0, cpu_dtack_n}, 64'h1);
        check("rs_no_sel",   {62'h0, tgt_sel_n},   64'h3);
        check("rs_no_berr",  {63'h0, cpu_berr_n},  64'h1);
        tgt_dtack_n = 2'b11;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_bus_router.md
# cpu_bus_router

Parametrised CPU-side bus router that sits between the WF68K CPU interface and N memory/peripheral targets, such as block RAM/ROM and SDRAM. It decodes each 68k-style bus cycle against per-target address regions. It then runs a registered request/acknowledge handshake with the selected target and returns read data and `dtack_n` to the CPU. Unmapped cycles and cycles with no target response produce a bus error.

## Interface
Parameters:
- `NUM_TARGETS`, 2: number of target ports; legal range 1..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; must be a multiple of 16.
- `REGION_BASE`, {32'h0, 32'h0}: packed `NUM_TARGETS*ADDR_W` bits; target i occupies slice [i*ADDR_W +: ADDR_W].
- `REGION_MASK`, {32'h0, 32'hFFF8_0000}: packed the same way; target 0 is the bottom 512 KB (block RAM), target 1 is catch-all (SDRAM).
- `TIMEOUT_CYCLES`, 255: wait-state limit before a bus error; 0 disables the timeout.

Ports:
- `CLK_114` in 1: the single clock; all logic is rising-edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_as_n` in 1: address strobe, active-low.
- `cpu_rw_n` in 1: 1 = read, 0 = write.
- `cpu_be_n` in DATA_W/8: byte enables (UDS/LDS/UDS2/LDS2), active-low.
- `cpu_rdata` out DATA_W: registered read data.
- `cpu_dtack_n` out 1: acknowledge to the CPU, active-low.
- `cpu_berr_n` out 1: bus error to the CPU, active-low.
- `tgt_sel_n` out NUM_TARGETS: one-hot-low target select.
- `tgt_rw_n` out NUM_TARGETS: per-target read/write; an unselected target sees 1 (read).
- `tgt_addr` out ADDR_W: latched address, shared by all targets.
- `tgt_wdata` out DATA_W: latched write data, shared.
- `tgt_be_n` out DATA_W/8: latched byte enables, shared.
- `tgt_rdata` in NUM_TARGETS*DATA_W: per-target read data.
- `tgt_dtack_n` in NUM_TARGETS: per-target acknowledge, active-low.
- `active_tgt` out max(1,$clog2(NUM_TARGETS)): index of the target currently selected.

## Operation
- **Decode rule.** A target matches when `(addr & MASK[i]) == BASE[i]`. When several targets match, the lowest index wins. When none matches, the cycle is unmapped.
- **IDLE**
  - When `cpu_as_n` is sampled low, latch addr, wdata, be_n and rw_n, then go to DECODE.
- **DECODE**
  - Compute the target from the latched address.
  - Hit: assert the chosen `tgt_sel_n[i]`=0, drive `tgt_rw_n[i]`=rw, load `active_tgt`, clear the wait counter, go to WAIT.
  - Miss: go to ERR.
- **WAIT**
  - `tgt_dtack_n[active]`=0: capture `tgt_rdata[active]` into `cpu_rdata` (reads only; writes leave it unchanged), deassert select, go to ACK.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES` (and that value is not 0), deassert select and go to ERR.
- **ACK**
  - `cpu_dtack_n`=0 until `cpu_as_n` is sampled high, then go to IDLE.
- **ERR**
  - `cpu_berr_n`=0 until `cpu_as_n` is sampled high, then go to IDLE.
- **Abort.** If `cpu_as_n` goes high in DECODE or WAIT, drop everything and return to IDLE with no acknowledge and no error.
- **Strict precedence:** abort > dtack > timeout. When a dtack arrives on the same cycle the timeout would fire, the cycle completes normally.
- **Ignored inputs.** Dtacks from non-selected targets are ignored.
- **Wait counter.** Width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.

## Timing
- **Reset values:**
  - `cpu_dtack_n`=1, `cpu_berr_n`=1.
  - `tgt_sel_n` all 1, `tgt_rw_n` all 1.
  - `cpu_rdata`=0, `tgt_addr`=0, `tgt_wdata`=0, `tgt_be_n` all 1.
  - `active_tgt`=0, state IDLE.
- **Reset during a cycle.** Reset asserted mid-cycle forces all of the above immediately, asynchronously. No stale acknowledge survives reset release.
- **Cycle timeline:**
  - Edge 0: AS sampled low; inputs latched.
  - Edge 1: select is driven.
  - If the target asserts dtack_n before edge k, the CPU sees `cpu_dtack_n`=0 after edge k+1. For a zero-wait target, the minimum round trip from AS to dtack is 3 edges.
- **Read data.** `cpu_rdata` is valid on or before the edge where `cpu_dtack_n` falls, and is held until the next read capture.
- **Select width.** Select is held for the whole WAIT. It falls one edge after the dtack is sampled.
- **Back-to-back cycles.** After AS rises there is at least one IDLE cycle before a new cycle is latched.

## Structure
- **Package `cpu_bus_pkg`:**
  - state enum (IDLE, DECODE, WAIT, ACK, ERR);
  - the default region constants for block RAM (base 0, mask `32'hFFF8_0000`) and the SDRAM catch-all;
  - the `NUM_TARGETS` limit.
- **Sub-module `bus_region_decode`:** purely combinational priority matcher, taking addr, BASE and MASK and producing hit and index. It is reused by the host-side router.
- **Top-level FSM, counter and output registers** stay in `cpu_bus_router`.

## Test plan
- **Block RAM read.** Read at addr 0x0000_1000; target 0 dtack_n low 2 cycles after select with rdata 0x1234_5678. Expect: `tgt_sel_n`=2'b10, then `cpu_rdata`=0x1234_5678 with `cpu_dtack_n` low until AS rises.
- **SDRAM write.** Write at 0x0008_0000 with wdata 0xDEAD_BEEF and be_n 4'b0000. Expect: `tgt_sel_n`=2'b01, `tgt_rw_n[1]`=0, `tgt_wdata`=0xDEAD_BEEF, and `cpu_rdata` unchanged.
- **Timeout.** Set `TIMEOUT_CYCLES`=4 and never assert target dtack. Expect: `cpu_berr_n` low after 4 WAIT cycles and select released.
- **Unmapped address.** Set target 1 MASK=0xFF00_0000 and BASE=0x0100_0000, then access 0x0200_0000. Expect: berr with no select ever asserted.
- **Abort and collision.**
  - Raise AS during WAIT. Expect: no dtack and no berr, and the next cycle decodes normally.
  - Make target dtack coincide with the timeout cycle. Expect: dtack, not berr.
- **Reset mid-WAIT.** Pulse `RESET_N` low during WAIT. Expect: all outputs at their reset values within the same cycle, and no acknowledge after release.
